// File: rtl/glip_uart_egress_arbiter_if.sv
// Byte-path bundle between the egress arbiter and its neighbours: the egress
// FIFO, the credit logic and the UART transmitter.
// master: the arbiter's view; slave: the view of the surrounding blocks.
interface glip_uart_egress_arbiter_if;
   logic [7:0]  data_in_data;
   logic        data_in_valid;
   logic        data_in_ready;
   logic        can_send;
   logic        transfer;
   logic        credit_req;
   logic [13:0] credit_val;
   logic        credit_ack;
   logic [7:0]  out_data;
   logic        out_enable;
   logic        out_done;
   logic        error;

   modport master (
      input  data_in_data, data_in_valid, can_send, credit_req, credit_val, out_done,
      output data_in_ready, transfer, credit_ack, out_data, out_enable, error
   );

   modport slave (
      output data_in_data, data_in_valid, can_send, credit_req, credit_val, out_done,
      input  data_in_ready, transfer, credit_ack, out_data, out_enable, error
   );
endinterface

// File: rtl/glip_uart_egress_arbiter.sv
// Shares the UART transmit byte path between payload data and credit messages.
// Payload bytes equal to ESC are sent twice; a credit grant goes out as the
// three-byte message ESC, {2'b01, credit[13:8]}, credit[7:0].
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no unit in flight; pick credit message first, else data byte
// DATA     | sending the latched payload byte
// DATA_ESC | sending the second ESC of an escaped payload byte
// CTRL0    | sending ESC, first byte of a credit message
// CTRL1    | sending {2'b01, credit[13:8]}
// CTRL2    | sending credit[7:0]; ack to the credit logic on out_done
module glip_uart_egress_arbiter #(
   parameter logic [7:0] ESC = 8'hFE
) (
   input logic                        clk,
   input logic                        rst,
   glip_uart_egress_arbiter_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      DATA_ESC,
      CTRL0,
      CTRL1,
      CTRL2
   } state_t;

   // Tag in the top two bits keeps the second message byte in 0x40-0x7F,
   // so the receiver never confuses it with an escaped payload ESC.
   localparam logic [1:0] CTRL_TAG = 2'b01;

   state_t      state;
   logic [7:0]  byte_q;
   logic [13:0] credit_q;
   logic [7:0]  out_data_q;
   logic        out_enable_q;
   logic        error_q;
   logic        start_ctrl;
   logic        start_data;

   // IDLE decision: credit message wins over an eligible data byte.
   assign start_ctrl = (state == IDLE) && bus.credit_req;
   assign start_data = (state == IDLE) && !bus.credit_req &&
                       bus.data_in_valid && bus.can_send;

   // Unit sequencing; out_data/out_enable are registered so out_done never
   // reaches them combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         byte_q       <= 8'h00;
         credit_q     <= 14'h0000;
         out_data_q   <= 8'h00;
         out_enable_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ctrl) begin
                  credit_q     <= bus.credit_val;
                  out_data_q   <= ESC;
                  out_enable_q <= 1'b1;
                  state        <= CTRL0;
               end else if (start_data) begin
                  byte_q       <= bus.data_in_data;
                  out_data_q   <= bus.data_in_data;
                  out_enable_q <= 1'b1;
                  state        <= DATA;
               end
            end
            DATA: begin
               if (bus.out_done) begin
                  if (byte_q == ESC) begin
                     out_data_q <= ESC;
                     state      <= DATA_ESC;
                  end else begin
                     out_data_q   <= 8'h00;
                     out_enable_q <= 1'b0;
                     state        <= IDLE;
                  end
               end
            end
            DATA_ESC: begin
               if (bus.out_done) begin
                  out_data_q   <= 8'h00;
                  out_enable_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            CTRL0: begin
               if (bus.out_done) begin
                  out_data_q <= {CTRL_TAG, credit_q[13:8]};
                  state      <= CTRL1;
               end
            end
            CTRL1: begin
               if (bus.out_done) begin
                  out_data_q <= credit_q[7:0];
                  state      <= CTRL2;
               end
            end
            CTRL2: begin
               if (bus.out_done) begin
                  out_data_q   <= 8'h00;
                  out_enable_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               out_data_q   <= 8'h00;
               out_enable_q <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

   // Sticky flag for a UART completion with no byte outstanding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error_q <= 1'b0;
      end else if (bus.out_done && !out_enable_q) begin
         error_q <= 1'b1;
      end
   end

   // The pop strobe and the credit payback coincide: one per payload byte,
   // the doubled ESC does not count against credit.
   assign bus.data_in_ready = start_data;
   assign bus.transfer      = start_data;
   assign bus.credit_ack    = (state == CTRL2) && bus.out_done;
   assign bus.out_data      = out_data_q;
   assign bus.out_enable    = out_enable_q;
   assign bus.error         = error_q;

endmodule

// File: tb/tb_glip_uart_egress_arbiter.sv
module tb_glip_uart_egress_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   glip_uart_egress_arbiter_if bus ();

   glip_uart_egress_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          is_ctrl;
      logic [7:0]  payload;
      logic [13:0] credit;
      int          nbytes;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
   } vec_t;

   vec_t vecs[9];

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] src_q[$];
   logic [7:0] byte_log[$];
   int   n_xfer, n_ack, n_rdy, n_rise, n_fall, zero_run, last_gap;
   logic prev_en;
   bit   seen_en;
   bit   busy;
   int   cnt;
   logic do_done;
   logic s_en, s_rdy, s_xfer, s_ack;
   logic [7:0] s_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive_src();
      bus.data_in_valid = (src_q.size() > 0);
      bus.data_in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
   endtask

   task automatic clear_stats();
      byte_log.delete();
      n_xfer = 0; n_ack = 0; n_rdy = 0; n_rise = 0; n_fall = 0;
      zero_run = 0; last_gap = -1; seen_en = 0;
   endtask

   // One clock: sample at negedge, update FIFO/requester/UART model after posedge.
   // The UART model raises out_done three cycles after it picks up a byte.
   task automatic cycle();
      @(negedge clk);
      s_en   = bus.out_enable;
      s_data = bus.out_data;
      s_rdy  = bus.data_in_ready;
      s_xfer = bus.transfer;
      s_ack  = bus.credit_ack;
      if (s_xfer) n_xfer++;
      if (s_ack)  n_ack++;
      if (s_rdy)  n_rdy++;
      if (s_en && !prev_en) n_rise++;
      if (!s_en && prev_en) n_fall++;
      if (s_en) begin
         if (!prev_en && seen_en) last_gap = zero_run;
         zero_run = 0;
         seen_en  = 1;
      end else begin
         zero_run++;
      end
      prev_en = s_en;
      do_done = 1'b0;
      if (busy) begin
         if (cnt == 0) begin
            do_done = 1'b1;
            busy    = 0;
         end else begin
            cnt--;
         end
      end else if (s_en && !bus.out_done) begin
         busy = 1;
         cnt  = 1;
         byte_log.push_back(s_data);
      end
      @(posedge clk);
      #1;
      if (s_rdy && src_q.size() > 0) void'(src_q.pop_front());
      drive_src();
      if (s_ack) bus.credit_req = 1'b0;
      bus.out_done = do_done;
   endtask

   task automatic run_until_fall(input string name, input int target, input int budget);
      int k;
      k = 0;
      while (n_fall < target && k < budget) begin
         cycle();
         k++;
      end
      if (n_fall < target) chk({name, "_timeout"}, 32'(n_fall), 32'(target));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic chk_log(input string name, input int idx, input logic [7:0] exp);
      logic [7:0] act;
      act = (idx < byte_log.size()) ? byte_log[idx] : 8'hxx;
      chk(name, 32'(act), 32'(exp));
   endtask

   initial begin
      vecs[0] = '{0, 8'h12, 14'h0000, 1, 8'h12, 8'h00, 8'h00};
      vecs[1] = '{0, 8'h34, 14'h0000, 1, 8'h34, 8'h00, 8'h00};
      vecs[2] = '{0, 8'hFE, 14'h0000, 2, 8'hFE, 8'hFE, 8'h00};
      vecs[3] = '{0, 8'hFD, 14'h0000, 1, 8'hFD, 8'h00, 8'h00};
      vecs[4] = '{1, 8'h00, 14'h1234, 3, 8'hFE, 8'h52, 8'h34};
      vecs[5] = '{1, 8'h00, 14'h3FFF, 3, 8'hFE, 8'h7F, 8'hFF};
      vecs[6] = '{1, 8'h00, 14'h0000, 3, 8'hFE, 8'h40, 8'h00};
      vecs[7] = '{0, 8'h00, 14'h0000, 1, 8'h00, 8'h00, 8'h00};
      vecs[8] = '{1, 8'h00, 14'h00FE, 3, 8'hFE, 8'h40, 8'hFE};

      rst = 1'b1;
      bus.data_in_data = 8'h00; bus.data_in_valid = 1'b0; bus.can_send = 1'b0;
      bus.credit_req = 1'b0; bus.credit_val = 14'h0; bus.out_done = 1'b0;
      busy = 0; cnt = 0; prev_en = 1'b0;
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_enable", 32'(bus.out_enable), 32'h0);
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_ready", 32'(bus.data_in_ready), 32'h0);
      chk("rst_ack", 32'(bus.credit_ack), 32'h0);
      chk("rst_error", 32'(bus.error), 32'h0);
      rst = 1'b0;
      idle(2);

      // Table of single units.
      for (int v = 0; v < 9; v++) begin
         bit flipped;
         int k;
         flipped = 0;
         clear_stats();
         bus.can_send = 1'b1;
         if (vecs[v].is_ctrl) begin
            bus.credit_val = vecs[v].credit;
            bus.credit_req = 1'b1;
         end else begin
            src_q.push_back(vecs[v].payload);
            drive_src();
         end
         k = 0;
         while (n_fall < 1 && k < 60) begin
            cycle();
            k++;
            if (vecs[v].is_ctrl && n_rise > 0 && !flipped) begin
               bus.credit_val = ~vecs[v].credit;
               flipped = 1;
            end
         end
         if (n_fall < 1) chk($sformatf("vec%0d_timeout", v), 32'(n_fall), 32'h1);
         idle(3);
         chk($sformatf("vec%0d_nbytes", v), 32'(byte_log.size()), 32'(vecs[v].nbytes));
         chk_log($sformatf("vec%0d_b0", v), 0, vecs[v].b0);
         if (vecs[v].nbytes > 1) chk_log($sformatf("vec%0d_b1", v), 1, vecs[v].b1);
         if (vecs[v].nbytes > 2) chk_log($sformatf("vec%0d_b2", v), 2, vecs[v].b2);
         chk($sformatf("vec%0d_xfer", v), 32'(n_xfer), vecs[v].is_ctrl ? 32'h0 : 32'h1);
         chk($sformatf("vec%0d_ack", v), 32'(n_ack), vecs[v].is_ctrl ? 32'h1 : 32'h0);
         chk($sformatf("vec%0d_units", v), 32'(n_rise), 32'h1);
      end

      // Two plain bytes back to back: one idle cycle between units.
      clear_stats();
      src_q.push_back(8'h12); src_q.push_back(8'h34); drive_src();
      run_until_fall("plain", 2, 80);
      idle(3);
      chk_log("plain_b0", 0, 8'h12);
      chk_log("plain_b1", 1, 8'h34);
      chk("plain_xfer", 32'(n_xfer), 32'h2);
      chk("plain_gap", 32'(last_gap), 32'h1);

      // Credit request raised during DATA_ESC waits for the escape pair.
      clear_stats();
      src_q.push_back(8'hFE); drive_src();
      begin
         int k;
         k = 0;
         while (byte_log.size() < 2 && k < 40) begin cycle(); k++; end
         if (byte_log.size() < 2) chk("esc_pair_timeout", 32'(byte_log.size()), 32'h2);
      end
      bus.credit_val = 14'h0155;
      bus.credit_req = 1'b1;
      run_until_fall("esc_then_ctrl", 2, 80);
      idle(3);
      chk("esc_ctrl_nbytes", 32'(byte_log.size()), 32'h5);
      chk_log("esc_ctrl_b0", 0, 8'hFE);
      chk_log("esc_ctrl_b1", 1, 8'hFE);
      chk_log("esc_ctrl_b2", 2, 8'hFE);
      chk_log("esc_ctrl_b3", 3, 8'h41);
      chk_log("esc_ctrl_b4", 4, 8'h55);
      chk("esc_ctrl_units", 32'(n_rise), 32'h2);
      chk("esc_ctrl_xfer", 32'(n_xfer), 32'h1);
      chk("esc_ctrl_ack", 32'(n_ack), 32'h1);

      // Simultaneous credit and data request in IDLE: control goes first.
      clear_stats();
      src_q.push_back(8'h77); drive_src();
      bus.credit_val = 14'h0ABC;
      bus.credit_req = 1'b1;
      run_until_fall("simul", 2, 80);
      idle(3);
      chk_log("simul_b0", 0, 8'hFE);
      chk_log("simul_b1", 1, 8'h4A);
      chk_log("simul_b2", 2, 8'hBC);
      chk_log("simul_b3", 3, 8'h77);
      chk("simul_gap", 32'(last_gap), 32'h1);
      chk("simul_ack", 32'(n_ack), 32'h1);

      // Flow gating with a spurious out_done in the blocked window.
      clear_stats();
      bus.can_send = 1'b0;
      src_q.push_back(8'h55); drive_src();
      idle(10);
      chk("gate_error_before", 32'(bus.error), 32'h0);
      bus.out_done = 1'b1;
      idle(10);
      chk("gate_ready", 32'(n_rdy), 32'h0);
      chk("gate_enable", 32'(n_rise), 32'h0);
      chk("gate_error_set", 32'(bus.error), 32'h1);
      bus.can_send = 1'b1;
      run_until_fall("gate_release", 1, 40);
      idle(3);
      chk_log("gate_b0", 0, 8'h55);
      chk("gate_error_sticky", 32'(bus.error), 32'h1);

      // Reset in the middle of CTRL1 abandons the message.
      clear_stats();
      bus.credit_val = 14'h1234;
      bus.credit_req = 1'b1;
      begin
         int k;
         k = 0;
         while (byte_log.size() < 2 && k < 40) begin cycle(); k++; end
         if (byte_log.size() < 2) chk("rst_ctrl1_timeout", 32'(byte_log.size()), 32'h2);
      end
      chk_log("rst_ctrl1_byte", 1, 8'h52);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_enable", 32'(bus.out_enable), 32'h0);
      chk("rst_async_ack", 32'(bus.credit_ack), 32'h0);
      bus.credit_req = 1'b0;
      bus.out_done   = 1'b0;
      busy = 0;
      idle(2);
      rst = 1'b0;
      idle(5);
      chk("post_rst_ack", 32'(n_ack), 32'h0);
      chk("post_rst_enable", 32'(bus.out_enable), 32'h0);
      chk("post_rst_data", 32'(bus.out_data), 32'h0);
      chk("post_rst_error", 32'(bus.error), 32'h0);
      chk("post_rst_bytes", 32'(byte_log.size()), 32'h2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/glip_uart_egress_arbiter.md
# glip_uart_egress_arbiter

Shares the single UART transmit byte path between the egress data stream and the credit control channel. Data bytes are sent only while the peer has credit (`can_send`). Data bytes equal to the escape value 0xFE are doubled. Credit grants are framed as 3-byte control messages that take priority at unit boundaries. It sits between the egress FIFO and credit logic on one side and the UART transmitter on the other.

## Interface
- `ESC`, default 8'hFE: escape byte value; fixed by the link protocol and not to be overridden.
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `data_in_data`  in  8  egress payload byte
- `data_in_valid`  in  1  payload byte available
- `data_in_ready`  out  1  single-cycle pop strobe, asserted when the byte is taken
- `can_send`  in  1  peer owes credit; a data unit may start only when 1
- `transfer`  out  1  single-cycle pulse, coincident with `data_in_ready`; one payload byte consumed (payback to debtor)
- `credit_req`  in  1  level; a credit message is pending; held until `credit_ack`
- `credit_val`  in  14  credit amount; sampled on the cycle the message is started
- `credit_ack`  out  1  single-cycle pulse on `out_done` of the last message byte
- `out_data`  out  8  byte to UART transmitter, registered
- `out_enable`  out  1  byte request to UART, registered; held until `out_done`
- `out_done`  in  1  single-cycle pulse; UART finished current byte
- `error`  out  1  sticky protocol error

## Operation
- **Units.** The arbiter issues atomic units:
  - data unit: 1 byte, or 2 bytes (ESC, ESC) when the payload byte equals ESC;
  - control unit: 3 bytes, ESC, {2'b01, credit[13:8]}, credit[7:0].
  - The second control byte lies in 0x40–0x7F and is never ESC, so the receiver can distinguish it from an escaped payload byte.
- **FSM states:** IDLE, DATA, DATA_ESC, CTRL0, CTRL1, CTRL2.
- **IDLE, priority order:**
  1. `credit_req` → latch `credit_val`, go to CTRL0.
  2. Else `data_in_valid` & `can_send` → pulse `data_in_ready` and `transfer`, latch byte, go to DATA.
  3. Else stay in IDLE.
- **DATA:** drives the latched byte. On `out_done`:
  - byte == ESC → go to DATA_ESC;
  - otherwise → go to IDLE.
- **DATA_ESC:** drives ESC; on `out_done` → IDLE.
- **CTRL0 → CTRL1 → CTRL2:** each advances on `out_done`. On `out_done` in CTRL2, pulse `credit_ack` and go to IDLE.
- **Atomicity:** a unit is never interrupted.
  - `credit_req` rising mid-data-unit waits for that unit to finish.
  - `can_send` falling mid-unit has no effect on the unit in progress.
- **Credit sampling:** the latched credit is held for the whole message. A `credit_val` change after CTRL0 entry is ignored.
- **`transfer` counting:** one pulse per payload byte. An escaped byte still produces exactly one pulse; the escape byte does not count against credit.
- **`error`:** set when `out_done` arrives while `out_enable` is 0. Cleared only by `rst`.

## Timing
- **Reset:** on `rst` assertion, immediately:
  - outputs `out_enable`=0, `out_data`=0, `data_in_ready`=0, `transfer`=0, `credit_ack`=0, `error`=0;
  - FSM=IDLE; latched byte and credit cleared.
  - A unit in progress is abandoned with no ack and no further pulses.
- **Unit start:** decision made in IDLE at cycle N. `out_enable`=1 and `out_data` valid from cycle N+1.
- **Within a unit:** `out_done` at cycle M → `out_data` shows the next byte at M+1. `out_enable` stays 1, so there are no gap cycles.
- **Unit end:** `out_done` on the last byte at M → `out_enable`=0 at M+1 (FSM in IDLE at M+1). The next unit's `out_enable` rises at M+2 at the earliest, giving exactly one idle cycle between units.
- **`credit_ack`:** asserted in cycle M, combinational with `out_done` in CTRL2. The requester must drop `credit_req` by M+1, which is the next IDLE decision.
- **Simultaneous requests in IDLE:** `credit_req` & data-eligible → control wins. Data is served in the following IDLE unless another `credit_req` is present.
- **No combinational paths** from `out_done` to `out_enable` or `out_data`.

## Test plan
- **Reset:** assert `rst` mid-CTRL1 → `out_enable` drops in the same cycle, no `credit_ack`; after release the arbiter sits in IDLE with all outputs 0.
- **Plain data:** `can_send`=1, bytes 0x12, 0x34, `out_done` 3 cycles after each enable → `out_data` shows 0x12 then 0x34, 2 `transfer` pulses, 1 idle cycle between units.
- **Escaped data:** push byte 0xFE → `out_data` shows 0xFE, 0xFE back-to-back, `out_enable` held across both, exactly 1 `transfer` pulse.
- **Credit message:** `credit_req`=1 with `credit_val`=14'h1234 → bytes 0xFE, 0x52, 0x34 in order, one `credit_ack` on the third `out_done`. Changing `credit_val` after CTRL0 does not alter the bytes.
- **Priority and atomicity:**
  - `credit_req` raised during DATA_ESC → the escape pair completes, then the control message follows;
  - `credit_req` and `data_in_valid` both raised in IDLE → the control message is sent first.
- **Flow gating and error:** `can_send`=0 with `data_in_valid`=1 → no `data_in_ready` and `out_enable` stays 0 for 20 cycles. A spurious `out_done` in that window sets `error`=1, which stays set until `rst`.
